// File: rtl/player_input_conditioner.sv
// Synchronizes and debounces six player buttons, captures each player's choice on press,
// and launches separated player_clk pulses with player* held stable around them.
module player_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn,
    input  logic [2:0] sw1,
    input  logic [2:0] sw2,
    input  logic [2:0] sw3,
    input  logic [2:0] sw4,
    input  logic [2:0] sw5,
    input  logic [2:0] sw6,
    input  logic       hold,
    output logic [2:0] player1,
    output logic [2:0] player2,
    output logic [2:0] player3,
    output logic [2:0] player4,
    output logic [2:0] player5,
    output logic [2:0] player6,
    output logic [5:0] player_clk,
    output logic       busy
);
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CW-1:0] P_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [5:0]    btn_s1, btn_s2;
    logic [17:0]   sw_s1, sw_s2;
    logic [5:0]    deb, deb_q;
    logic [DW-1:0] db_cnt [6];
    logic [5:0]    pending, fire_mask, accept;
    logic [2:0]    choice [6];
    logic [2:0]    player_r [6];
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= {sw6, sw5, sw4, sw3, sw2, sw1};
            sw_s2  <= sw_s1;
        end
    end

    // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 6; i++) begin
                if (btn_s2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A press already pending keeps its first choice; hold drops new presses.
    assign accept = deb & ~deb_q & ~pending & {6{~hold}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= '0;
            fire_mask  <= '0;
            player_clk <= '0;
            for (int i = 0; i < 6; i++) begin
                choice[i]   <= '0;
                player_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++)
                if (accept[i]) choice[i] <= sw_s2[3*i +: 3];

            if (hold)
                pending <= '0;
            else if (state == IDLE && pending != '0)
                pending <= accept;
            else
                pending <= pending | accept;

            case (state)
                IDLE: begin
                    if (pending != '0 && !hold) begin
                        fire_mask <= pending;
                        for (int i = 0; i < 6; i++)
                            if (pending[i]) player_r[i] <= choice[i];
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    player_clk <= fire_mask;
                    cnt        <= '0;
                    state      <= PULSE;
                end
                PULSE: begin
                    if (cnt == P_LAST) begin
                        player_clk <= '0;
                        cnt        <= '0;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == G_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign player1 = player_r[0];
    assign player2 = player_r[1];
    assign player3 = player_r[2];
    assign player4 = player_r[3];
    assign player5 = player_r[4];
    assign player6 = player_r[5];
endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized button/hold/reset traffic.
module tb_player_input_conditioner;
    localparam int D = 16;
    localparam int P = 4;
    localparam int G = 4;

    logic       clk = 0;
    logic       reset = 1;
    logic [5:0] btn = '0;
    logic [2:0] sw [6];
    logic       hold = 0;
    logic [2:0] p1, p2, p3, p4, p5, p6;
    logic [5:0] player_clk;
    logic       busy;
    logic [2:0] pl [6];

    int total = 0;
    int bad = 0;
    bit cmp_en = 0;
    int pulse_cycles = 0;

    always #5 clk = ~clk;

    assign pl[0] = p1; assign pl[1] = p2; assign pl[2] = p3;
    assign pl[3] = p4; assign pl[4] = p5; assign pl[5] = p6;

    player_input_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .sw1(sw[0]), .sw2(sw[1]), .sw3(sw[2]), .sw4(sw[3]), .sw5(sw[4]), .sw6(sw[5]),
        .hold(hold),
        .player1(p1), .player2(p2), .player3(p3), .player4(p4), .player5(p5), .player6(p6),
        .player_clk(player_clk), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a launch at edge L means busy after edges L..L+P+G,
    // player_clk = mask after edges L+1..L+P, next launch no earlier than L+P+G+2.
    int         edge_n = 0;
    int         L = -1000;
    logic [5:0] m_mask, m_s1, m_s2, m_deb, m_debq, m_pend, m_pclk;
    logic       m_busy;
    int         m_run [6];
    logic [2:0] m_sw1 [6], m_sw2 [6], m_choice [6], m_player [6];

    initial begin
        logic [5:0] rise, acc, npend;
        bit idle_before;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                L = -1000; m_mask = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0; m_pend = 0;
                for (int i = 0; i < 6; i++) begin
                    m_run[i] = 0; m_sw1[i] = 0; m_sw2[i] = 0; m_choice[i] = 0; m_player[i] = 0;
                end
            end else begin
                rise = m_deb & ~m_debq;
                idle_before = (edge_n - 1) > (L + P + G);
                acc = rise & ~m_pend & {6{~hold}};
                if (hold) npend = 0;
                else if (idle_before && m_pend != 0) begin
                    L = edge_n;
                    m_mask = m_pend;
                    for (int i = 0; i < 6; i++) if (m_pend[i]) m_player[i] = m_choice[i];
                    npend = acc;
                end else npend = m_pend | acc;
                for (int i = 0; i < 6; i++) if (acc[i]) m_choice[i] = m_sw2[i];
                m_pend = npend;
                m_debq = m_deb;
                for (int i = 0; i < 6; i++) begin
                    if (m_s2[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == D) begin m_deb[i] = ~m_deb[i]; m_run[i] = 0; end
                    end else m_run[i] = 0;
                end
                m_s2 = m_s1; m_s1 = btn;
                for (int i = 0; i < 6; i++) begin m_sw2[i] = m_sw1[i]; m_sw1[i] = sw[i]; end
            end
            m_pclk = (edge_n >= L + 1 && edge_n <= L + P) ? m_mask : 6'd0;
            m_busy = (edge_n >= L && edge_n <= L + P + G);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (player_clk != 0) pulse_cycles++;
                check("model player_clk", 32'(player_clk), 32'(m_pclk));
                check("model busy", 32'(busy), 32'(m_busy));
                for (int i = 0; i < 6; i++) check("model player", 32'(pl[i]), 32'(m_player[i]));
            end
        end
    end

    task automatic wait_pulse(input int n, input string name, output int at);
        bit found = 0;
        at = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (player_clk != 0) begin found = 1; at = edge_n; break; end
        end
        if (!found) check({name, " pulse timeout"}, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t1, t2, pc0, cd [6];
        bit seen_low;
        for (int i = 0; i < 6; i++) sw[i] = 0;

        // Single press; edge 0 is the first posedge after this negedge.
        idle(3);
        cmp_en = 1;
        check("reset player_clk", 32'(player_clk), 0);
        check("reset busy", 32'(busy), 0);
        check("reset player2", 32'(p2), 0);
        sw[1] = 3'b101; reset = 0; btn[1] = 1;
        repeat (20) @(posedge clk); #1;
        check("e19 player2", 32'(p2), 5);
        check("e19 busy", 32'(busy), 1);
        check("e19 player_clk", 32'(player_clk), 0);
        @(posedge clk); #1;
        check("e20 player_clk", 32'(player_clk), 32'h02);
        repeat (3) @(posedge clk); #1;
        check("e23 player_clk", 32'(player_clk), 32'h02);
        @(posedge clk); #1;
        check("e24 player_clk", 32'(player_clk), 0);
        repeat (3) @(posedge clk); #1;
        check("e27 busy", 32'(busy), 1);
        @(posedge clk); #1;
        check("e28 busy", 32'(busy), 0);
        @(negedge clk); btn[1] = 0;
        idle(30);

        // Bounce: 5-cycle highs never reach the debounce threshold.
        pc0 = pulse_cycles;
        for (int k = 0; k < 6; k++) begin
            btn[0] = 1; idle(5);
            btn[0] = 0; idle(5);
        end
        idle(30);
        check("bounce pulses", 32'(pulse_cycles - pc0), 0);
        check("bounce player1", 32'(p1), 0);

        // Simultaneous presses fire together.
        sw[2] = 3'd1; sw[4] = 3'd4; idle(3);
        btn[2] = 1; btn[4] = 1;
        wait_pulse(60, "simul", t1);
        check("simul mask", 32'(player_clk), 32'h14);
        check("simul player3", 32'(p3), 1);
        check("simul player5", 32'(p5), 4);
        @(negedge clk); btn[2] = 0; btn[4] = 0;
        idle(40);

        // Press landing during the first pulse launches 10 cycles after it.
        btn[0] = 1; idle(3); btn[5] = 1;
        wait_pulse(60, "first", t1);
        check("first mask", 32'(player_clk), 32'h01);
        seen_low = 0; t2 = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (player_clk == 0) seen_low = 1;
            else if (seen_low) begin t2 = edge_n; break; end
        end
        check("second mask", 32'(player_clk), 32'h20);
        check("launch period", 32'(t2 - t1), 10);
        @(negedge clk); btn[0] = 0; btn[5] = 0;
        idle(40);

        // Hold discards a press that debounces under it.
        hold = 1; btn[3] = 1; idle(30);
        pc0 = pulse_cycles;
        hold = 0; idle(25);
        check("hold pulses", 32'(pulse_cycles - pc0), 0);
        btn[3] = 0; idle(25);
        btn[3] = 1;
        wait_pulse(40, "after hold", t1);
        check("after hold mask", 32'(player_clk), 32'h08);
        idle(15); btn[3] = 0; idle(30);

        // Reset during the second pulse cycle; button stays held through reset.
        sw[1] = 3'd6; idle(3); btn[1] = 1;
        wait_pulse(40, "pre-reset", t1);
        @(posedge clk);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        check("rst player_clk", 32'(player_clk), 0);
        check("rst busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) check("rst player", 32'(pl[i]), 0);
        @(negedge clk); reset = 0;
        wait_pulse(40, "held through reset", t1);
        check("held mask", 32'(player_clk), 32'h02);
        check("held player2", 32'(p2), 6);
        idle(15); btn[1] = 0; idle(30);

        // Randomized traffic against the model.
        for (int i = 0; i < 6; i++) cd[i] = $urandom_range(1, 40);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (cd[i] == 0) begin btn[i] = ~btn[i]; cd[i] = $urandom_range(1, 40); end
                else cd[i]--;
                if ($urandom_range(0, 49) == 0) sw[i] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 199) == 0) hold = ~hold;
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk); reset = 0; hold = 0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
